// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial converter with a ready/valid upstream
// handshake, a pause input that freezes the stream, and a one-cycle done
// flag on the last bit of each word. Back-to-back words stream gap-free.
module bit_serializer #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             pause,
    output logic             x,
    output logic             x_valid,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    logic [0:0]       state_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] shift_reg;
    logic             x_reg;
    logic             x_valid_reg;

    logic             accept;
    logic             at_last;
    logic             emit_bit;
    logic             load_bit;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] load_shifted;

    // The bit currently on x lives in x_reg; shift_reg holds the word already
    // advanced by one position, so its emitting end is always the next bit.
    // That keeps every register bit in use and x a plain flop output.
    if (MSB_FIRST) begin : g_msb
        assign emit_bit     = shift_reg[WIDTH-1];
        assign shifted      = {shift_reg[WIDTH-2:0], 1'b0};
        assign load_bit     = in_data[WIDTH-1];
        assign load_shifted = {in_data[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
        assign emit_bit     = shift_reg[0];
        assign shifted      = {1'b0, shift_reg[WIDTH-1:1]};
        assign load_bit     = in_data[0];
        assign load_shifted = {1'b0, in_data[WIDTH-1:1]};
    end

    // Handshake and end-of-word flags; pause suppresses both done and the
    // mid-stream ready so a frozen last bit cannot be overwritten.
    always_comb begin
        at_last  = (state_reg == ST_SHIFT) && (count_reg == LAST_COUNT);
        done     = at_last && !pause;
        in_ready = (state_reg == ST_IDLE) || done;
        accept   = in_valid && in_ready;
    end

    // State, bit counter, shift register and registered serial outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            count_reg   <= '0;
            shift_reg   <= '0;
            x_reg       <= IDLE_LEVEL;
            x_valid_reg <= 1'b0;
        end else if (accept) begin
            // Covers both a fresh start from IDLE and a reload on the done edge.
            state_reg   <= ST_SHIFT;
            count_reg   <= '0;
            shift_reg   <= load_shifted;
            x_reg       <= load_bit;
            x_valid_reg <= 1'b1;
        end else if (state_reg == ST_SHIFT && !pause) begin
            if (count_reg == LAST_COUNT) begin
                state_reg   <= ST_IDLE;
                count_reg   <= '0;
                shift_reg   <= '0;
                x_reg       <= IDLE_LEVEL;
                x_valid_reg <= 1'b0;
            end else begin
                count_reg <= count_reg + CW'(1);
                shift_reg <= shifted;
                x_reg     <= emit_bit;
            end
        end
    end

    assign x       = x_reg;
    assign x_valid = x_valid_reg;

endmodule

// File: tb/tb_bit_serializer.sv
// Testbench for bit_serializer: two instances share all inputs (one MSB-first
// idle-low, one LSB-first idle-high) and are compared every cycle against a
// word/index reference model, through directed scenarios and random traffic.
module tb_bit_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         pause = 1'b0;

    logic rdy_m, x_m, xv_m, done_m;
    logic rdy_l, x_l, xv_l, done_l;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a held word, the index of the bit on x, and a busy flag.
    bit           m_busy = 1'b0;
    logic [W-1:0] m_word = '0;
    int           m_idx  = 0;

    // Observation tallies for directed scenarios.
    int           n_xv = 0;
    int           n_done = 0;
    logic [31:0]  seq_m = '0;
    logic [W-1:0] seq_l = '0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_m), .pause(pause), .x(x_m), .x_valid(xv_m), .done(done_m)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_l (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_l), .pause(pause), .x(x_l), .x_valid(xv_l), .done(done_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_tally();
        n_xv   = 0;
        n_done = 0;
        seq_m  = '0;
        seq_l  = '0;
    endtask

    // One clock cycle: drive inputs, check all outputs, then advance the model.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic p);
        logic exp_rdy, exp_done, exp_xm, exp_xl;
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        pause    = p;
        #1;
        exp_rdy  = !m_busy || (m_idx == W - 1 && !p);
        exp_done = m_busy && m_idx == W - 1 && !p;
        exp_xm   = m_busy ? m_word[W-1-m_idx] : 1'b0;
        exp_xl   = m_busy ? m_word[m_idx] : 1'b1;
        check("msb_x",       32'(x_m),    32'(exp_xm));
        check("msb_x_valid", 32'(xv_m),   32'(m_busy));
        check("msb_ready",   32'(rdy_m),  32'(exp_rdy));
        check("msb_done",    32'(done_m), 32'(exp_done));
        check("lsb_x",       32'(x_l),    32'(exp_xl));
        check("lsb_x_valid", 32'(xv_l),   32'(m_busy));
        check("lsb_ready",   32'(rdy_l),  32'(exp_rdy));
        check("lsb_done",    32'(done_l), 32'(exp_done));
        $display("cyc v=%0b d=%02h p=%0b | x_m=%0b x_l=%0b xv=%0b rdy=%0b done=%0b",
                 v, d, p, x_m, x_l, xv_m, rdy_m, done_m);
        if (xv_m && !p) begin
            seq_m = {seq_m[30:0], x_m};
            seq_l = {x_l, seq_l[W-1:1]};
        end
        if (xv_m) n_xv++;
        if (done_m) n_done++;
        @(posedge clk);
        if (v && exp_rdy) begin
            m_busy = 1'b1;
            m_word = d;
            m_idx  = 0;
        end else if (m_busy && !p) begin
            if (m_idx == W - 1) m_busy = 1'b0;
            else m_idx++;
        end
    endtask

    // Asynchronous reset pulse in the middle of a cycle; outputs must clear at once.
    task automatic async_reset();
        @(negedge clk);
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_msb_x_valid", 32'(xv_m), 32'd0);
        check("rst_msb_x",       32'(x_m),  32'd0);
        check("rst_lsb_x_valid", 32'(xv_l), 32'd0);
        check("rst_lsb_x",       32'(x_l),  32'd1);
        $display("async reset applied");
        m_busy = 1'b0;
        m_idx  = 0;
        @(posedge clk);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        // Reset state while reset_n is held low.
        #12;
        check("init_msb_x_valid", 32'(xv_m),  32'd0);
        check("init_msb_x",       32'(x_m),   32'd0);
        check("init_lsb_x",       32'(x_l),   32'd1);
        check("init_ready",       32'(rdy_m), 32'd1);
        check("init_done",        32'(done_m), 32'd0);
        @(posedge clk);
        #2 reset_n = 1'b1;

        // 0xA5 accepted on the first edge after reset: 8 bits, one done.
        clear_tally();
        cycle(1'b1, 8'hA5, 1'b0);
        for (int i = 0; i < W + 1; i++) cycle(1'b0, 8'h00, 1'b0);
        check("a5_msb_seq",   seq_m[7:0], 32'hA5);
        check("a5_lsb_seq",   32'(seq_l), 32'hA5);
        check("a5_xv_cycles", n_xv,       32'd8);
        check("a5_done_cnt",  n_done,     32'd1);

        // 0x01: LSB-first emits a single leading one.
        clear_tally();
        cycle(1'b1, 8'h01, 1'b0);
        for (int i = 0; i < W + 1; i++) cycle(1'b0, 8'h00, 1'b0);
        check("01_lsb_seq", 32'(seq_l), 32'h01);
        check("01_msb_seq", seq_m[7:0], 32'h01);

        // 0xFF then 0x00 held valid: reload on the done edge, 16-bit gap-free run.
        clear_tally();
        cycle(1'b1, 8'hFF, 1'b0);
        for (int i = 0; i < W; i++) cycle(1'b1, 8'h00, 1'b0);
        for (int i = 0; i < W + 1; i++) cycle(1'b0, 8'h00, 1'b0);
        check("b2b_seq",       seq_m[15:0], 32'hFF00);
        check("b2b_xv_cycles", n_xv,        32'd16);
        check("b2b_done_cnt",  n_done,      32'd2);

        // 0xA5 with a three-cycle pause on the third bit.
        clear_tally();
        cycle(1'b1, 8'hA5, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < W - 2 + 1; i++) cycle(1'b0, 8'h00, 1'b0);
        check("pause_seq",       seq_m[7:0], 32'hA5);
        check("pause_xv_cycles", n_xv,       32'd11);
        check("pause_done_cnt",  n_done,     32'd1);

        // Reset during bit 5 of 0xC3, then 0x3C streams cleanly.
        cycle(1'b1, 8'hC3, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0);
        async_reset();
        clear_tally();
        cycle(1'b1, 8'h3C, 1'b0);
        for (int i = 0; i < W + 1; i++) cycle(1'b0, 8'h00, 1'b0);
        check("3c_seq",       seq_m[7:0], 32'h3C);
        check("3c_xv_cycles", n_xv,       32'd8);

        // Valid asserted during bits 1-7 must not disturb the active word.
        clear_tally();
        cycle(1'b1, 8'h96, 1'b0);
        for (int i = 0; i < W - 1; i++) cycle(1'b1, W'($urandom), 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        check("ignore_seq", seq_m[7:0], 32'h96);

        // Pause in IDLE does not block acceptance.
        cycle(1'b1, 8'h5A, 1'b1);
        for (int i = 0; i < W + 2; i++) cycle(1'b0, 8'h00, 1'b0);

        // Random traffic with occasional mid-stream resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) async_reset();
            else cycle($urandom_range(0, 9) < 7, W'($urandom), $urandom_range(0, 4) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
